// File: rtl/ibuf_ctrl_pkg.sv
// ============================================================================
// Module   : ibuf_ctrl_pkg
// Purpose  : Shared sizing constants and helpers for the instruction buffer
//            pointer/occupancy controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ibuf_ctrl_pkg;

  localparam int IBUF_DEPTH = 8;
  localparam int IBUF_PTR_W = 3;
  localparam int IBUF_CNT_W = 4;

  // Number of asserted bits in a two-slot group (0..2).
  function automatic logic [1:0] count2(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage : ibuf_ctrl_pkg

`default_nettype wire

// File: rtl/ibuf_ctrl_alloc.sv
// ============================================================================
// Module   : ibuf_ctrl_alloc
// Purpose  : Compacts the two IF slots onto consecutive free buffer entries
//            and produces the array write enables and indices.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ibuf_ctrl_alloc
  import ibuf_ctrl_pkg::*;
#(
  parameter int PTR_W = IBUF_PTR_W
) (
  input  logic             accept,
  input  logic             receive_flag1,
  input  logic             receive_flag2,
  input  logic [PTR_W-1:0] tail,
  output logic             wr_en1,
  output logic [PTR_W-1:0] wr_idx1,
  output logic             wr_en2,
  output logic [PTR_W-1:0] wr_idx2,
  output logic [1:0]       npush
);

  logic w_take1;
  logic w_take2;

  assign w_take1 = accept & receive_flag1;
  assign w_take2 = accept & receive_flag2;

  assign wr_en1  = w_take1;
  assign wr_en2  = w_take2;
  assign wr_idx1 = tail;
  // Slot 2 slides down onto tail when slot 1 carries nothing.
  assign wr_idx2 = tail + PTR_W'(receive_flag1);
  assign npush   = count2(w_take1, w_take2);

endmodule : ibuf_ctrl_alloc

`default_nettype wire

// File: rtl/ibuf_ctrl.sv
// ============================================================================
// Module   : ibuf_ctrl
// Purpose  : Head/tail/occupancy and IF/ID handshake controller for the
//            dual-port instruction buffer (storage lives elsewhere).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ibuf_ctrl
  import ibuf_ctrl_pkg::*;
#(
  parameter int DEPTH = IBUF_DEPTH,
  parameter int PTR_W = IBUF_PTR_W,
  parameter int CNT_W = IBUF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             stop,
  input  logic             receive_flag1,
  input  logic             receive_flag2,
  input  logic             launch_flag1,
  input  logic             launch_flag2,
  output logic             wr_en1,
  output logic [PTR_W-1:0] wr_idx1,
  output logic             wr_en2,
  output logic [PTR_W-1:0] wr_idx2,
  output logic [PTR_W-1:0] rd_idx1,
  output logic [PTR_W-1:0] rd_idx2,
  output logic             sendout_flag1,
  output logic             sendout_flag2,
  output logic             instbuf_full,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] c_full_thresh = CNT_W'(DEPTH - 2);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_cnt;

  logic       w_accept;
  logic       w_pop1;
  logic       w_pop2;
  logic [1:0] w_npush;
  logic [1:0] w_npop;

  assign rd_idx1       = r_head;
  assign rd_idx2       = r_head + PTR_W'(1);
  assign sendout_flag1 = (r_cnt != '0);
  assign sendout_flag2 = (r_cnt >= CNT_W'(2));
  // Fewer than two free entries; evaluated on registered occupancy only.
  assign instbuf_full  = (r_cnt > c_full_thresh);
  assign count         = r_cnt;

  assign w_accept = ~instbuf_full & ~stop & ~flush;

  ibuf_ctrl_alloc #(
    .PTR_W (PTR_W)
  ) u_alloc (
    .accept        (w_accept),
    .receive_flag1 (receive_flag1),
    .receive_flag2 (receive_flag2),
    .tail          (r_tail),
    .wr_en1        (wr_en1),
    .wr_idx1       (wr_idx1),
    .wr_en2        (wr_en2),
    .wr_idx2       (wr_idx2),
    .npush         (w_npush)
  );

  // In-order retirement: the second output can only go with the first.
  assign w_pop1 = launch_flag1 & sendout_flag1 & ~stop & ~flush;
  assign w_pop2 = w_pop1 & launch_flag2 & sendout_flag2;
  assign w_npop = count2(w_pop1, w_pop2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else if (flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else if (!stop) begin
      r_head <= r_head + PTR_W'(w_npop);
      r_tail <= r_tail + PTR_W'(w_npush);
      r_cnt  <= r_cnt + CNT_W'(w_npush) - CNT_W'(w_npop);
    end
  end

endmodule : ibuf_ctrl

`default_nettype wire

// File: tb/tb_ibuf_ctrl.sv
// ============================================================================
// Module   : tb_ibuf_ctrl
// Purpose  : Self-checking bench for ibuf_ctrl against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ibuf_ctrl;

  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0, stop = 1'b0;
  logic       receive_flag1 = 1'b0, receive_flag2 = 1'b0;
  logic       launch_flag1 = 1'b0, launch_flag2 = 1'b0;
  logic       wr_en1, wr_en2, sendout_flag1, sendout_flag2, instbuf_full;
  logic [2:0] wr_idx1, wr_idx2, rd_idx1, rd_idx2;
  logic [3:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: queue of occupied buffer indices, oldest first.
  int q[$];
  int m_head = 0;
  int m_tail = 0;

  always #5 clk = ~clk;

  ibuf_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .stop          (stop),
    .receive_flag1 (receive_flag1),
    .receive_flag2 (receive_flag2),
    .launch_flag1  (launch_flag1),
    .launch_flag2  (launch_flag2),
    .wr_en1        (wr_en1),
    .wr_idx1       (wr_idx1),
    .wr_en2        (wr_en2),
    .wr_idx2       (wr_idx2),
    .rd_idx1       (rd_idx1),
    .rd_idx2       (rd_idx2),
    .sendout_flag1 (sendout_flag1),
    .sendout_flag2 (sendout_flag2),
    .instbuf_full  (instbuf_full),
    .count         (count)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_head = 0;
    m_tail = 0;
  endtask

  // Check all outputs against the model for the inputs currently applied,
  // then advance the model to the state after the coming clock edge.
  task automatic compare_and_step();
    bit full, acc, e1, e2;
    int npop, i1, i2;
    full = (D - q.size()) < 2;
    acc  = !full && !stop && !flush;
    e1   = acc && receive_flag1;
    e2   = acc && receive_flag2;
    i1   = m_tail;
    i2   = receive_flag1 ? (m_tail + 1) % D : m_tail;
    chk("count",         count,         q.size());
    chk("sendout_flag1", sendout_flag1, q.size() >= 1);
    chk("sendout_flag2", sendout_flag2, q.size() >= 2);
    chk("instbuf_full",  instbuf_full,  full);
    chk("rd_idx1",       rd_idx1,       m_head);
    chk("rd_idx2",       rd_idx2,       (m_head + 1) % D);
    chk("wr_en1",        wr_en1,        e1);
    chk("wr_en2",        wr_en2,        e2);
    if (e1) chk("wr_idx1", wr_idx1, i1);
    if (e2) chk("wr_idx2", wr_idx2, i2);

    npop = 0;
    if (!stop && !flush && launch_flag1 && q.size() >= 1)
      npop = (launch_flag2 && q.size() >= 2) ? 2 : 1;
    if (flush) begin
      model_reset();
    end else begin
      for (int k = 0; k < npop; k++) begin
        void'(q.pop_front());
        m_head = (m_head + 1) % D;
      end
      if (e1) begin q.push_back(m_tail); m_tail = (m_tail + 1) % D; end
      if (e2) begin q.push_back(m_tail); m_tail = (m_tail + 1) % D; end
    end
  endtask

  task automatic cycle(input bit r1, input bit r2, input bit l1, input bit l2,
                       input bit st, input bit fl);
    @(negedge clk);
    receive_flag1 = r1; receive_flag2 = r2;
    launch_flag1  = l1; launch_flag2  = l2;
    stop = st; flush = fl;
    #1;
    compare_and_step();
    @(posedge clk);
    #1;
    {receive_flag1, receive_flag2, launch_flag1, launch_flag2, stop, flush} = '0;
  endtask

  initial begin
    model_reset();
    #12;
    // Reset values, hand-computed.
    chk("rst_count", count, 0);
    chk("rst_sendout_flag1", sendout_flag1, 0);
    chk("rst_sendout_flag2", sendout_flag2, 0);
    chk("rst_full", instbuf_full, 0);
    chk("rst_rd_idx1", rd_idx1, 0);
    chk("rst_rd_idx2", rd_idx2, 1);
    chk("rst_wr_en1", wr_en1, 0);
    chk("rst_wr_en2", wr_en2, 0);
    @(negedge clk);
    rst = 1'b1;

    // First push of two, then visibility one cycle later.
    @(negedge clk);
    receive_flag1 = 1; receive_flag2 = 1;
    #1;
    chk("first_wr_idx1", wr_idx1, 0);
    chk("first_wr_idx2", wr_idx2, 1);
    chk("first_sendout_flag1", sendout_flag1, 0);
    compare_and_step();
    @(posedge clk); #1;
    {receive_flag1, receive_flag2} = '0;
    chk("first_count", count, 2);
    chk("first_sendout_flag2", sendout_flag2, 1);

    // Fill to 6 (not full), then 8 (full), then a dropped push.
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    chk("fill6_full", instbuf_full, 0);
    cycle(1, 1, 0, 0, 0, 0);
    chk("fill8_full", instbuf_full, 1);
    @(negedge clk);
    receive_flag1 = 1; receive_flag2 = 1;
    #1;
    chk("drop_wr_en1", wr_en1, 0);
    chk("drop_wr_en2", wr_en2, 0);
    compare_and_step();
    @(posedge clk); #1;
    {receive_flag1, receive_flag2} = '0;
    chk("drop_count", count, 8);

    // Drain to head=6,count=2, then pop2/push2 across the wrap.
    cycle(0, 0, 1, 1, 0, 0);
    cycle(0, 0, 1, 1, 0, 0);
    cycle(0, 0, 1, 1, 0, 0);
    chk("wrap_rd_idx1", rd_idx1, 6);
    chk("wrap_rd_idx2", rd_idx2, 7);
    cycle(1, 1, 1, 1, 0, 0);
    chk("wrap_rd_idx1_b", rd_idx1, 0);
    chk("wrap_count", count, 2);
    cycle(1, 1, 1, 1, 0, 0);
    cycle(1, 1, 1, 1, 0, 0);
    cycle(1, 1, 1, 1, 0, 0);

    // Ordering: launch2 alone is ignored.
    cycle(1, 0, 0, 0, 0, 0);
    chk("order_count3", count, 3);
    cycle(0, 0, 0, 1, 0, 0);
    chk("order_no_pop", count, 3);
    cycle(0, 0, 1, 0, 0, 0);
    chk("order_pop1", count, 2);

    // Slot-2-only push lands at tail.
    @(negedge clk);
    receive_flag2 = 1;
    #1;
    chk("only2_wr_en1", wr_en1, 0);
    chk("only2_wr_en2", wr_en2, 1);
    chk("only2_wr_idx2", wr_idx2, m_tail);
    compare_and_step();
    @(posedge clk); #1;
    receive_flag2 = 0;
    chk("only2_count", count, 3);

    // Stop holds; flush beats stop and pushes.
    cycle(1, 1, 0, 0, 0, 0);
    chk("pre_stop_count", count, 5);
    cycle(1, 1, 1, 1, 1, 0);
    chk("stop_count", count, 5);
    cycle(1, 1, 1, 1, 1, 1);
    chk("flush_count", count, 0);
    chk("flush_rd_idx1", rd_idx1, 0);
    chk("flush_sendout_flag1", sendout_flag1, 0);

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      bit fl, st, r1, r2, l1, l2;
      r1 = ($urandom_range(0, 9) < 7);
      r2 = ($urandom_range(0, 9) < 6);
      l1 = ($urandom_range(0, 9) < 5);
      l2 = ($urandom_range(0, 9) < 5);
      st = ($urandom_range(0, 9) == 0);
      fl = ($urandom_range(0, 39) == 0);
      cycle(r1, r2, l1, l2, st, fl);
    end

    // Asynchronous reset asserted between edges.
    cycle(1, 1, 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_count", count, 0);
    chk("async_rd_idx1", rd_idx1, 0);
    chk("async_rd_idx2", rd_idx2, 1);
    chk("async_sendout_flag1", sendout_flag1, 0);
    model_reset();
    #1;
    rst = 1'b1;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ibuf_ctrl

`default_nettype wire
